cap_vramwr_engine: RTL

- Parametrised AXI4 write engine for the capture path. It drains a first-word-fall-through pixel-word FIFO, already in the ACLK domain, into VRAM as fixed-length INCR bursts.
- Successor to the single-buffer capture writer. Adds configurable data width, burst length and N-frame ring buffering, plus frame-done/error reporting.
- Sits between the capture FIFO and the capture top's M_AXI write channels. Constant AXI fields (ID, LOCK, CACHE, PROT, QOS, USER) stay in the top.

---
 rtl/cap_vramwr_engine.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cap_vramwr_engine.sv
// Capture-path AXI4 write engine: drains a FWFT pixel FIFO into a ring of VRAM
// frame buffers as fixed-length INCR bursts, one burst outstanding at a time.
module cap_vramwr_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int NUM_BUF    = 2,
  parameter int BUF_W      = 2,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    START,
  input  logic                    FRAME_SYNC,
  input  logic [31:0]             BASEADDR,
  input  logic [19:0]             FRAME_WORDS,
  input  logic                    CLR_ERR,
  input  logic [DATA_WIDTH-1:0]   FIFO_RDATA,
  input  logic [CNT_WIDTH-1:0]    FIFO_COUNT,
  output logic                    FIFO_RDEN,
  output logic [31:0]             M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic                    FRAME_DONE,
  output logic [BUF_W-1:0]        WR_BUF,
  output logic [BUF_W-1:0]        LAST_BUF,
  output logic                    BUSY,
  output logic                    ERR_RESP,
  output logic                    ERR_SYNC
);

  localparam int          STRB_W      = DATA_WIDTH / 8;
  localparam int          SIZE_LOG    = $clog2(STRB_W);
  localparam int          BEAT_W      = $clog2(BURST_LEN);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * STRB_W);
  localparam logic [19:0] LEN_MASK    = ~20'(BURST_LEN - 1);

  // Valid/ready: a transfer happens on a rising ACLK edge where VALID and READY
  // are both high; the sender holds VALID and its payload stable until then.
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [19:0]       eff_words, eff_q, word_cnt;
  logic [28:0]       addr_q;
  logic [31:0]       buf_off, eff_bytes;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BUF_W-1:0]  wr_buf, last_buf;
  logic              err_resp, err_sync;
  logic              start_frame, fifo_ready, aw_hs, w_hs, b_hs, wlast, frame_last;
  logic              sync_err_evt, resp_err_evt, buf_wrap;

  assign eff_words    = FRAME_WORDS & LEN_MASK;
  assign eff_bytes    = 32'(eff_q) << SIZE_LOG;
  assign start_frame  = START && FRAME_SYNC && (eff_words != '0);
  assign fifo_ready   = 32'(FIFO_COUNT) >= 32'(BURST_LEN);
  assign aw_hs        = (state == S_ADDR) && M_AXI_AWREADY;
  assign w_hs         = (state == S_DATA) && M_AXI_WREADY;
  assign b_hs         = (state == S_RESP) && M_AXI_BVALID;
  assign wlast        = (state == S_DATA) && (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign frame_last   = (word_cnt + 20'(BURST_LEN)) == eff_q;
  assign buf_wrap     = wr_buf == BUF_W'(NUM_BUF - 1);
  assign sync_err_evt = FRAME_SYNC && (state != S_IDLE);
  assign resp_err_evt = b_hs && (M_AXI_BRESP != 2'b00);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_frame) state_nxt = S_WAIT;
      S_WAIT: if (fifo_ready) state_nxt = S_ADDR;
      S_ADDR: if (aw_hs) state_nxt = S_DATA;
      S_DATA: if (w_hs && wlast) state_nxt = S_RESP;
      S_RESP: begin
        if (b_hs) begin
          if (frame_last) state_nxt = S_DONE;
          else if (START) state_nxt = S_WAIT;
          else            state_nxt = S_IDLE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // buf_off tracks WR_BUF*eff bytes incrementally, so no multiplier is needed.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      eff_q    <= '0;
      word_cnt <= '0;
      addr_q   <= '0;
      buf_off  <= '0;
      beat_cnt <= '0;
      wr_buf   <= '0;
      last_buf <= BUF_W'(NUM_BUF - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (start_frame) begin
            eff_q    <= eff_words;
            word_cnt <= '0;
            addr_q   <= 29'(BASEADDR + buf_off);
          end
        end
        S_ADDR: if (aw_hs) addr_q <= addr_q + BURST_BYTES[28:0];
        S_DATA: begin
          if (w_hs) beat_cnt <= wlast ? '0 : beat_cnt + 1'b1;
        end
        S_RESP: if (b_hs) word_cnt <= word_cnt + 20'(BURST_LEN);
        S_DONE: begin
          last_buf <= wr_buf;
          wr_buf   <= buf_wrap ? '0 : wr_buf + 1'b1;
          buf_off  <= buf_wrap ? '0 : buf_off + eff_bytes;
        end
        default: ;
      endcase
    end
  end

  // Sticky errors: a new event in the same cycle as CLR_ERR keeps the flag set.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_resp <= 1'b0;
      err_sync <= 1'b0;
    end else begin
      err_resp <= resp_err_evt | (err_resp & ~CLR_ERR);
      err_sync <= sync_err_evt | (err_sync & ~CLR_ERR);
    end
  end

  assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
  assign M_AXI_AWSIZE  = 3'(SIZE_LOG);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = state == S_ADDR;
  assign M_AXI_AWADDR  = M_AXI_AWVALID ? {3'b001, addr_q} : 32'h0;
  assign M_AXI_WVALID  = state == S_DATA;
  assign M_AXI_WDATA   = M_AXI_WVALID ? FIFO_RDATA : '0;
  assign M_AXI_WLAST   = wlast;
  assign FIFO_RDEN     = w_hs;
  assign M_AXI_BREADY  = state == S_RESP;
  assign FRAME_DONE    = state == S_DONE;
  assign BUSY          = state != S_IDLE;
  assign WR_BUF        = wr_buf;
  assign LAST_BUF      = last_buf;
  assign ERR_RESP      = err_resp;
  assign ERR_SYNC      = err_sync;

endmodule
